// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-enable divider bank: output modes and per-channel control.
package clk_div_pkg;

    localparam logic MODE_PULSE  = 1'b0;
    localparam logic MODE_SQUARE = 1'b1;

    // Control half of a channel's configuration; the divisor width is a module parameter.
    typedef struct packed {
        logic mode;
        logic en;
    } ch_ctrl_t;

    localparam ch_ctrl_t CTRL_RESET = '{mode: MODE_PULSE, en: 1'b1};

endpackage

// File: rtl/clock_divider_channel.sv
// One programmable clock-enable generator: counter, config registers and output/rise registers.
module clock_divider_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    input  logic             wr_mode,
    input  logic             wr_chan_en,
    output logic             dclk,
    output logic             dclk_rise
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    ch_ctrl_t         ctrl;

    logic wrap_c;
    logic half_c;
    logic parked_c;
    logic next_dclk_c;

    // >= rather than == so a divisor shrunk mid-count wraps on the next edge
    always_comb begin
        wrap_c      = (cnt >= div);
        half_c      = (cnt > (div >> 1));
        parked_c    = !ctrl.en || (div == '0);
        next_dclk_c = (ctrl.mode == MODE_SQUARE) ? half_c : wrap_c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= DIV_W'(1);
            div       <= DIV_W'(DEFAULT_DIV);
            ctrl      <= CTRL_RESET;
            dclk      <= 1'b0;
            dclk_rise <= 1'b0;
        end else begin
            if (wr) begin
                div       <= wr_div;
                ctrl.mode <= wr_mode;
                ctrl.en   <= wr_chan_en;
            end
            // The counter keeps running across config writes; only restart or parking clears it.
            if (restart || parked_c) begin
                cnt       <= DIV_W'(1);
                dclk      <= 1'b0;
                dclk_rise <= 1'b0;
            end else begin
                cnt       <= wrap_c ? DIV_W'(1) : cnt + DIV_W'(1);
                dclk      <= next_dclk_c;
                dclk_rise <= next_dclk_c & ~dclk;
            end
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Bank of independent clock-enable dividers sharing one clock, with a single config write port.
module clock_divider_bank #(
    parameter  int unsigned CHANNELS    = 4,
    parameter  int unsigned DIV_W       = 32,
    parameter  int unsigned DEFAULT_DIV = 4,
    localparam int unsigned CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                restart,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [DIV_W-1:0]    wr_div,
    input  logic                wr_mode,
    input  logic                wr_chan_en,
    output logic [CHANNELS-1:0] dclk,
    output logic [CHANNELS-1:0] dclk_rise
);

    logic [CHANNELS-1:0] wr_sel_c;

    // Out-of-range channel numbers match no instance, so such writes fall on the floor.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign wr_sel_c[i] = wr_en && (32'(wr_ch) == 32'(i));

        clock_divider_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .restart    (restart),
            .wr         (wr_sel_c[i]),
            .wr_div     (wr_div),
            .wr_mode    (wr_mode),
            .wr_chan_en (wr_chan_en),
            .dclk       (dclk[i]),
            .dclk_rise  (dclk_rise[i])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank: directed tables, hand sequences and random traffic vs a model.
module tb_clock_divider_bank;

    localparam int unsigned CHANNELS = 4;
    localparam int unsigned DIV_W    = 32;
    localparam int unsigned CH_W     = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                restart;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [DIV_W-1:0]    wr_div;
    logic                wr_mode;
    logic                wr_chan_en;
    logic [CHANNELS-1:0] dclk;
    logic [CHANNELS-1:0] dclk_rise;

    always #5 clk = ~clk;

    clock_divider_bank #(
        .CHANNELS    (CHANNELS),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .restart    (restart),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_div     (wr_div),
        .wr_mode    (wr_mode),
        .wr_chan_en (wr_chan_en),
        .dclk       (dclk),
        .dclk_rise  (dclk_rise)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: position within the period, divisor as plain integers.
    longint m_pos [CHANNELS];
    longint m_div [CHANNELS];
    bit     m_sq  [CHANNELS];
    bit     m_en  [CHANNELS];
    bit     m_d   [CHANNELS];
    bit     m_r   [CHANNELS];

    typedef struct {
        logic [3:0] d;
        logic [3:0] r;
    } vec_t;
    vec_t tbl [9];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        for (int c = 0; c < int'(CHANNELS); c++) begin
            if (!rst_n) begin
                m_pos[c] = 1; m_div[c] = 4; m_sq[c] = 0; m_en[c] = 1; m_d[c] = 0; m_r[c] = 0;
            end else begin
                bit nd;
                if (restart || !m_en[c] || m_div[c] == 0) begin
                    m_pos[c] = 1; m_d[c] = 0; m_r[c] = 0;
                end else begin
                    // square: high once position passes the lower half of the period
                    nd = m_sq[c] ? (2 * m_pos[c] > m_div[c]) : (m_pos[c] >= m_div[c]);
                    m_r[c] = nd && !m_d[c];
                    m_d[c] = nd;
                    m_pos[c] = (m_pos[c] >= m_div[c]) ? 1 : m_pos[c] + 1;
                end
                if (wr_en && int'(wr_ch) == c) begin
                    m_div[c] = longint'(wr_div); m_sq[c] = wr_mode; m_en[c] = wr_chan_en;
                end
            end
        end
    endtask

    task automatic tick();
        logic [3:0] ed, er;
        @(posedge clk);
        model_edge();
        #1;
        for (int c = 0; c < int'(CHANNELS); c++) begin
            ed[c] = m_d[c];
            er[c] = m_r[c];
        end
        check("model_dclk", 32'(dclk), 32'(ed));
        check("model_rise", 32'(dclk_rise), 32'(er));
    endtask

    task automatic idle();
        restart = 1'b0; wr_en = 1'b0;
    endtask

    task automatic write(input int ch, input int unsigned div, input logic mode, input logic en);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_div = DIV_W'(div); wr_mode = mode; wr_chan_en = en;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic run_table(string name);
        for (int i = 0; i < 9; i++) begin
            tick();
            check({name, "_dclk"}, 32'(dclk), 32'(tbl[i].d));
            check({name, "_rise"}, 32'(dclk_rise), 32'(tbl[i].r));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] sq_d, sq_r;
        logic [6:0] p3_d;
        bit         found;

        // Default divisor 4, PULSE: all channels high together on every 4th edge after release.
        tbl[0] = '{4'h0, 4'h0}; tbl[1] = '{4'h0, 4'h0}; tbl[2] = '{4'h0, 4'h0};
        tbl[3] = '{4'hF, 4'hF}; tbl[4] = '{4'h0, 4'h0}; tbl[5] = '{4'h0, 4'h0};
        tbl[6] = '{4'h0, 4'h0}; tbl[7] = '{4'hF, 4'hF}; tbl[8] = '{4'h0, 4'h0};

        rst_n = 1'b0; restart = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
        wr_mode = 1'b0; wr_chan_en = 1'b0;
        tick(); tick();
        check("reset_dclk", 32'(dclk), 32'h0);
        check("reset_rise", 32'(dclk_rise), 32'h0);
        rst_n = 1'b1;
        run_table("defaults");

        // ch2 div=5 SQUARE, phase-aligned by a simultaneous restart.
        restart = 1'b1;
        write(2, 5, 1'b1, 1'b1);
        idle();
        check("restart_clear", 32'(dclk), 32'h0);
        sq_d = 10'b1110011100;
        sq_r = 10'b0010000100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("sq5_dclk", 32'(dclk[2]), 32'(sq_d[i]));
            check("sq5_rise", 32'(dclk_rise[2]), 32'(sq_r[i]));
        end

        // ch1: div=6, then shrink to 3 while position is 4.
        restart = 1'b1;
        write(1, 6, 1'b0, 1'b1);
        idle();
        tick(); tick(); tick();
        write(1, 3, 1'b0, 1'b1);
        check("shrink_wr_edge", 32'(dclk[1]), 32'h0);
        p3_d = 7'b1001001;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("shrink_dclk", 32'(dclk[1]), 32'(p3_d[i]));
        end

        // Parking by div=0 (ch0) and by en=0 (ch3), then re-enable with div=2.
        write(0, 0, 1'b0, 1'b1);
        write(3, 4, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("parked_dclk", 32'({dclk[3], dclk[0]}), 32'h0);
        end
        write(0, 2, 1'b0, 1'b1);
        check("reen0_e0", 32'(dclk[0]), 32'h0);
        tick();
        check("reen0_e1", 32'(dclk[0]), 32'h0);
        tick();
        check("reen0_e2", 32'(dclk[0]), 32'h1);
        write(3, 2, 1'b0, 1'b1);
        tick();
        check("reen3_e1", 32'(dclk[3]), 32'h0);
        tick();
        check("reen3_e2", 32'(dclk[3]), 32'h1);

        // Mixed phases, then restart aligns all channels with equal divisor.
        for (int c = 0; c < int'(CHANNELS); c++) begin
            write(c, 3, 1'b0, 1'b1);
            for (int k = 0; k < c + 1; k++) tick();
        end
        restart = 1'b1;
        tick();
        idle();
        check("align_restart", 32'(dclk), 32'h0);
        tick();
        check("align_e1", 32'(dclk), 32'h0);
        tick();
        check("align_e2", 32'(dclk), 32'h0);
        tick();
        check("align_e3", 32'(dclk), 32'hF);

        // Reset during a SQUARE high phase, with restart and a write also asserted.
        write(0, 4, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (dclk[0]) found = 1'b1;
        end
        check("sq_high_reached", 32'(found), 32'h1);
        rst_n = 1'b0; restart = 1'b1;
        wr_en = 1'b1; wr_ch = 2'd0; wr_div = 32'd7; wr_mode = 1'b1; wr_chan_en = 1'b1;
        tick();
        check("reset_win_dclk", 32'(dclk), 32'h0);
        check("reset_win_rise", 32'(dclk_rise), 32'h0);
        rst_n = 1'b1;
        idle();
        run_table("after_reset");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            rst_n      = ($urandom_range(0, 199) != 0);
            restart    = ($urandom_range(0, 24) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_ch      = CH_W'($urandom);
            wr_div     = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom) : DIV_W'($urandom_range(0, 9));
            wr_mode    = 1'($urandom);
            wr_chan_en = ($urandom_range(0, 7) != 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
